// File: rtl/prod_wr_arbiter.sv
// prod_wr_arbiter: round-robin arbiter granting one of two requesters a burst of writes into a FIFO
// Ports: prod_clk/prod_rst_n clock and async active-low reset; req0/1, len0/1, data0/1 requester side;
// gnt0/1 registered grants, ack0/1 per-word handshake; o_data/o_wr_en/i_full FIFO side;
// busy burst in progress, word_cnt free-running count of words written.
module prod_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 16,
  localparam int LEN_W = $clog2(MAX_BURST + 1)
) (
  input  logic                  prod_clk,
  input  logic                  prod_rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [LEN_W-1:0]      len0,
  input  logic [LEN_W-1:0]      len1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr_en,
  input  logic                  i_full,
  output logic                  busy,
  output logic [15:0]           word_cnt
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic rr, pick, last;
  logic [LEN_W-1:0] rem, len_pick, len_eff;
  assign pick = (req0 && req1) ? rr : req1;
  assign len_pick = pick ? len1 : len0;
  assign len_eff = (len_pick == '0) ? LEN_W'(1) :
                   (len_pick > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len_pick;
  assign last = o_wr_en && (rem == LEN_W'(1));
  always_ff @(posedge prod_clk or negedge prod_rst_n)
    if (!prod_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((req0 || req1) ? BURST : IDLE) : (last ? IDLE : BURST);
  always_comb begin
    busy = (state == BURST);
    o_wr_en = busy && !i_full;
    ack0 = o_wr_en && gnt0;
    ack1 = o_wr_en && gnt1;
    o_data = gnt1 ? data1 : gnt0 ? data0 : '0;
  end
  // The grant flops double as the record of which requester owns the burst.
  always_ff @(posedge prod_clk or negedge prod_rst_n)
    if (!prod_rst_n) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rr <= 1'b0;
      rem <= '0;
      word_cnt <= '0;
    end else if (state == IDLE) begin
      if (req0 || req1) begin
        gnt0 <= !pick;
        gnt1 <= pick;
        rem <= len_eff;
      end
    end else if (o_wr_en) begin
      rem <= rem - LEN_W'(1);
      word_cnt <= word_cnt + 16'd1;
      if (last) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
        rr <= gnt0;
      end
    end
endmodule

// File: tb/tb_prod_wr_arbiter.sv
// tb_prod_wr_arbiter: vector table, directed corner sequences and random traffic against a cycle model
module tb_prod_wr_arbiter;
  localparam int DW = 8;
  localparam int MAXB = 16;
  localparam int LEN_W = $clog2(MAXB + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 0, req1 = 0, i_full = 0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic gnt0, gnt1, ack0, ack1, o_wr_en, busy;
  logic [DW-1:0] o_data;
  logic [15:0] word_cnt;
  prod_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .prod_clk(clk), .prod_rst_n(rst_n), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .o_data(o_data), .o_wr_en(o_wr_en), .i_full(i_full), .busy(busy), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit m_busy, m_own, m_rr;
  int m_left, m_cnt;
  int nwr, viol, k;
  bit last_ack0;
  logic [DW-1:0] wrq[$];
  bit wro[$];
  typedef struct {
    bit r0, r1; int l0, l1; bit f; logic [7:0] d0, d1;
    bit g0, g1, wr, a0, a1; logic [7:0] dat; bit bz; int wc;
  } vec_t;
  vec_t tv[7];
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic do_reset();
    rst_n = 0; req0 = 0; req1 = 0; len0 = '0; len1 = '0; i_full = 0; data0 = '0; data1 = '0;
    #1;
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_ack0", ack0, 0); chk("rst_ack1", ack1, 0);
    chk("rst_wr_en", o_wr_en, 0); chk("rst_data", o_data, 0);
    chk("rst_busy", busy, 0); chk("rst_word_cnt", word_cnt, 0);
    m_busy = 0; m_rr = 0; m_cnt = 0; m_left = 0; m_own = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    nwr = 0; viol = 0; wrq.delete(); wro.delete();
  endtask
  // One clock of stimulus; outputs are compared at the falling edge against the model.
  task automatic cyc(input bit r0, input bit r1, input int l0, input int l1, input bit f);
    int rl;
    req0 = r0; req1 = r1; len0 = l0[LEN_W-1:0]; len1 = l1[LEN_W-1:0]; i_full = f;
    @(negedge clk);
    chk("gnt0", gnt0, m_busy && !m_own);
    chk("gnt1", gnt1, m_busy && m_own);
    chk("wr_en", o_wr_en, m_busy && !f);
    chk("ack0", ack0, m_busy && !f && !m_own);
    chk("ack1", ack1, m_busy && !f && m_own);
    chk("o_data", o_data, m_busy ? (m_own ? data1 : data0) : 8'h00);
    chk("busy", busy, m_busy);
    chk("word_cnt", word_cnt, m_cnt);
    if (o_wr_en) begin
      nwr++; wrq.push_back(o_data); wro.push_back(gnt1);
      if (i_full) viol++;
    end
    last_ack0 = ack0;
    if (!m_busy) begin
      if (r0 || r1) begin
        m_own = (r0 && r1) ? m_rr : r1;
        rl = m_own ? l1 : l0;
        m_left = (rl < 1) ? 1 : (rl > MAXB) ? MAXB : rl;
        m_busy = 1;
      end
    end else if (!f) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_rr = !m_own;
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic run_burst(input bit who, input int l);
    int b = 0;
    cyc(!who, who, l, l, 0);
    while (m_busy && b < 100) begin
      cyc(0, 0, 0, 0, 0);
      b++;
    end
    chk("burst_done", busy, 0);
  endtask
  initial begin
    tv[0] = '{1,0,2,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,0,0};
    tv[1] = '{0,0,2,0,0,8'h11,8'h55, 1,0,1,1,0,8'h11,1,0};
    tv[2] = '{0,1,2,5,1,8'h22,8'h55, 1,0,0,0,0,8'h22,1,1};
    tv[3] = '{0,1,2,5,0,8'h22,8'h55, 1,0,1,1,0,8'h22,1,1};
    tv[4] = '{1,1,2,0,0,8'h66,8'h33, 0,0,0,0,0,8'h00,0,2};
    tv[5] = '{1,0,2,0,0,8'h66,8'h44, 0,1,1,0,1,8'h44,1,2};
    tv[6] = '{0,0,2,0,0,8'h66,8'h44, 0,0,0,0,0,8'h00,0,3};
    do_reset();
    foreach (tv[i]) begin
      req0 = tv[i].r0; req1 = tv[i].r1; len0 = tv[i].l0[LEN_W-1:0]; len1 = tv[i].l1[LEN_W-1:0];
      i_full = tv[i].f; data0 = tv[i].d0; data1 = tv[i].d1;
      @(negedge clk);
      chk("tv_gnt0", gnt0, tv[i].g0); chk("tv_gnt1", gnt1, tv[i].g1);
      chk("tv_wr_en", o_wr_en, tv[i].wr); chk("tv_ack0", ack0, tv[i].a0);
      chk("tv_ack1", ack1, tv[i].a1); chk("tv_data", o_data, tv[i].dat);
      chk("tv_busy", busy, tv[i].bz); chk("tv_word_cnt", word_cnt, tv[i].wc);
      @(posedge clk); #1;
    end
    do_reset();
    k = 0; data0 = 8'hA0;
    cyc(1, 0, 4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      data0 = 8'hA0 + 8'(k);
      cyc(0, 0, 4, 0, 0);
      if (last_ack0) k++;
    end
    chk("burst4_writes", nwr, 4);
    for (int i = 0; i < 4; i++) chk("burst4_data", wrq[i], 8'hA0 + i);
    chk("burst4_word_cnt", word_cnt, 4);
    chk("burst4_busy", busy, 0);
    do_reset();
    repeat (12) cyc(1, 1, 2, 2, 0);
    chk("rr_writes", nwr, 8);
    for (int i = 0; i < 8; i++) chk("rr_order", wro[i], (i / 2) % 2);
    do_reset();
    cyc(0, 1, 0, 3, 0);
    cyc(0, 0, 0, 3, 0);
    repeat (4) cyc(0, 0, 0, 3, 1);
    for (int i = 0; i < 10 && m_busy; i++) cyc(0, 0, 0, 3, 0);
    chk("stall_writes", nwr, 3);
    chk("stall_full_writes", viol, 0);
    chk("stall_word_cnt", word_cnt, 3);
    do_reset();
    run_burst(0, 0);
    chk("len0_writes", nwr, 1);
    nwr = 0;
    run_burst(0, 31);
    chk("len31_writes", nwr, 16);
    do_reset();
    cyc(1, 0, 8, 0, 0);
    cyc(0, 0, 8, 0, 0);
    cyc(0, 0, 8, 0, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_writes", nwr, 2);
    do_reset();
    run_burst(1, 5);
    chk("post_rst_writes", nwr, 5);
    for (int i = 0; i < 5; i++) chk("post_rst_owner", wro[i], 1);
    chk("post_rst_word_cnt", word_cnt, 5);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      data0 = 8'($urandom); data1 = 8'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 3) == 0);
    end
    chk("rand_no_full_write", viol, 0);
    do_reset();
    for (int i = 0; i < 4096; i++) run_burst(0, 16);
    chk("wrap_zero", word_cnt, 0);
    run_burst(0, 1);
    chk("wrap_one", word_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prod_wr_arbiter.md
PROD_WR_ARBITER -- requirements
Module: prod_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every data path.
REQ-002 Parameter MAX_BURST, default 16, maximum words per burst; LEN_W = $clog2(MAX_BURST+1).
REQ-003 PROD_CLK  in  1  producer-domain clock; all state updates on rising edge.
REQ-004 PROD_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 REQ0 / REQ1  in  1 each  requester n asks for a write burst.
REQ-006 LEN0 / LEN1  in  LEN_W each  requested burst length, sampled at grant.
REQ-007 DATA0 / DATA1  in  DATA_WIDTH each  current word from requester n, held valid while GNTn.
REQ-008 GNT0 / GNT1  out  1 each  requester n owns the FIFO write port.
REQ-009 ACK0 / ACK1  out  1 each  current DATAn word written this cycle; requester advances next cycle.
REQ-010 O_DATA  out  DATA_WIDTH  write data to FIFO.
REQ-011 O_WR_EN  out  1  FIFO write enable.
REQ-012 I_FULL  in  1  FIFO full flag, producer domain.
REQ-013 BUSY  out  1  burst in progress.
REQ-014 WORD_CNT  out  16  total words written since reset.

Function
REQ-015 FSM states: IDLE, BURST; encoded in one register.
REQ-016 IDLE: no REQ -> stay IDLE; any REQ -> select winner, latch its LEN into remaining counter REM, enter BURST next cycle.
REQ-017 Arbitration: single request wins directly; both requesting -> winner is requester indicated by round-robin pointer RR.
REQ-018 RR updates only on burst completion: RR becomes the index not just served.
REQ-019 LEN of 0 is treated as 1; LEN > MAX_BURST is saturated to MAX_BURST.
REQ-020 GNTn is registered: 1 exactly while in BURST for winner n, 0 otherwise; GNT0 and GNT1 never both 1.
REQ-021 In BURST, O_WR_EN = !I_FULL (combinational); O_DATA = DATA of granted requester, 0 when not in BURST.
REQ-022 ACKn = O_WR_EN && GNTn, same cycle.
REQ-023 Each cycle with O_WR_EN=1: REM decrements by 1, WORD_CNT increments by 1.
REQ-024 WORD_CNT wraps from 16'hFFFF to 0.
REQ-025 I_FULL=1 in BURST: O_WR_EN=0, no ACK, REM and WORD_CNT hold; stall length unbounded.
REQ-026 Write with REM=1 completes burst: next state IDLE, GNT deasserts next cycle, RR updates.
REQ-027 Minimum one IDLE cycle between consecutive bursts; a new grant issues no earlier than the cycle after IDLE.
REQ-028 REQ deassertion during BURST is ignored; burst runs to LEN words.
REQ-029 REQ/LEN changes of the non-granted requester during BURST have no effect on the current burst.
REQ-030 BUSY = (state == BURST).
REQ-031 O_WR_EN never asserts while I_FULL=1 (FIFO overflow impossible).

Reset
REQ-032 PROD_RST_N=0 immediately forces state IDLE, REM=0, RR=0, WORD_CNT=0, GNT0/1=0, ACK0/1=0, O_WR_EN=0, O_DATA=0, BUSY=0.
REQ-033 Reset mid-burst abandons the burst; no partial write occurs after reset assertion; after release, first grant follows REQ-016/017 with RR=0.

Verification
REQ-034 REQ0=1, LEN0=4, DATA0=8'hA0..A3 (advanced on ACK0), I_FULL=0 -> GNT0 one cycle after REQ0, four consecutive O_WR_EN with O_DATA A0,A1,A2,A3, WORD_CNT=4, BUSY drops after 4th write.
REQ-035 REQ0=REQ1=1 continuously after reset, LEN0=LEN1=2 -> grant order 0,1,0,1; each burst 2 writes; one IDLE cycle between bursts; GNT0/GNT1 never overlap.
REQ-036 REQ1=1, LEN1=3, I_FULL=1 for cycles 2-5 of burst -> O_WR_EN=0 and ACK1=0 during stall, REM held; exactly 3 writes total, none while I_FULL=1.
REQ-037 LEN0=0 -> exactly 1 write; LEN0=31 with MAX_BURST=16 -> exactly 16 writes.
REQ-038 PROD_RST_N asserted after 2 of 8 writes -> all outputs 0 in same cycle, WORD_CNT=0; after release with REQ1 only, GNT1 and fresh burst of LEN1 words.
REQ-039 Preload WORD_CNT path by 65535 writes then 2 more -> WORD_CNT reads 1.
